// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the radix-4 multiplier sequencing controller:
// state encoding, operand byte select codes and default iteration count.
package mult_ctrl_pkg;

  localparam int unsigned N_ITER_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LD_AL = 3'd1,
    ST_LD_AM = 3'd2,
    ST_LD_BL = 3'd3,
    ST_LD_BM = 3'd4,
    ST_CLR   = 3'd5,
    ST_CALC  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam logic [1:0] SEL_AL = 2'd0;
  localparam logic [1:0] SEL_AM = 2'd1;
  localparam logic [1:0] SEL_BL = 2'd2;
  localparam logic [1:0] SEL_BM = 2'd3;

endpackage

// File: rtl/mult_iter_cnt.sv
// Radix-4 iteration counter: synchronous clear, enable, and terminal count
// at N_ITER-1 (self-clears when it is enabled at terminal count).
module mult_iter_cnt #(
  parameter int unsigned N_ITER = 8,
  parameter int unsigned CNT_W  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == CNT_W'(N_ITER - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (en_i && tc_o)) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/radix4_mult_ctrl.sv
// Sequencing controller for the radix-4 Booth 16x16 signed multiplier:
// gathers operand bytes, then drives clear/shift/accumulate strobes.
module radix4_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned N_ITER = N_ITER_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       byte_valid,
  output logic       byte_req,
  output logic [1:0] byte_sel,
  output logic       ldAl,
  output logic       ldAm,
  output logic       ldBl,
  output logic       ldBm,
  output logic       lastbit,
  output logic       pr_rst,
  output logic       ldP,
  output logic       shen,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  state_e state_q;
  state_e state_d;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;

  assign cnt_clr = (state_q == ST_CLR);
  assign cnt_en  = (state_q == ST_CALC);

  mult_iter_cnt #(
    .N_ITER (N_ITER),
    .CNT_W  (CNT_W)
  ) u_iter_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and output decode; load strobes follow byte_valid within their state.
  always_comb begin
    state_d  = state_q;
    byte_req = 1'b0;
    byte_sel = SEL_AL;
    ldAl     = 1'b0;
    ldAm     = 1'b0;
    ldBl     = 1'b0;
    ldBm     = 1'b0;
    lastbit  = 1'b0;
    pr_rst   = 1'b0;
    ldP      = 1'b0;
    shen     = 1'b0;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_d = ST_LD_AL;
      end
      ST_LD_AL: begin
        busy     = 1'b1;
        byte_req = 1'b1;
        byte_sel = SEL_AL;
        ldAl     = byte_valid;
        lastbit  = byte_valid;
        if (byte_valid) state_d = ST_LD_AM;
      end
      ST_LD_AM: begin
        busy     = 1'b1;
        byte_req = 1'b1;
        byte_sel = SEL_AM;
        ldAm     = byte_valid;
        if (byte_valid) state_d = ST_LD_BL;
      end
      ST_LD_BL: begin
        busy     = 1'b1;
        byte_req = 1'b1;
        byte_sel = SEL_BL;
        ldBl     = byte_valid;
        if (byte_valid) state_d = ST_LD_BM;
      end
      ST_LD_BM: begin
        busy     = 1'b1;
        byte_req = 1'b1;
        byte_sel = SEL_BM;
        ldBm     = byte_valid;
        if (byte_valid) state_d = ST_CLR;
      end
      ST_CLR: begin
        busy    = 1'b1;
        pr_rst  = 1'b1;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        ldP  = 1'b1;
        shen = 1'b1;
        if (cnt_tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_radix4_mult_ctrl.sv
// Bench for radix4_mult_ctrl: behavioural Booth datapath driven by the
// controller strobes, products checked against plain signed multiplication.
module tb_radix4_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_req, ldAl, ldAm, ldBl, ldBm, lastbit, pr_rst, ldP, shen;
  logic       ready, busy, done;
  logic [1:0] byte_sel;

  always #5 clk = ~clk;

  radix4_mult_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_req(byte_req), .byte_sel(byte_sel),
    .ldAl(ldAl), .ldAm(ldAm), .ldBl(ldBl), .ldBm(ldBm), .lastbit(lastbit),
    .pr_rst(pr_rst), .ldP(ldP), .shen(shen),
    .ready(ready), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host: presents the byte of the current operands selected by byte_sel.
  logic [15:0] cur_a = '0, cur_b = '0;
  logic [7:0]  byte_data;
  always_comb begin
    case (byte_sel)
      2'd0:    byte_data = cur_a[7:0];
      2'd1:    byte_data = cur_a[15:8];
      2'd2:    byte_data = cur_b[7:0];
      default: byte_data = cur_b[15:8];
    endcase
  end

  // Behavioural radix-4 Booth datapath: {A, appended bit}, B, partial product.
  logic        [16:0] ar;
  logic        [15:0] br;
  logic signed [19:0] pr, sum;
  logic        [31:0] prod;

  function automatic int booth_digit(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return 1;
      3'b011:         return 2;
      3'b100:         return -2;
      3'b101, 3'b110: return -1;
      default:        return 0;
    endcase
  endfunction

  always_comb sum = 20'(int'(pr) + booth_digit(ar[2:0]) * int'($signed(br)));
  assign prod = {pr[15:0], ar[16:1]};

  always @(posedge clk) begin
    if (ldAl)    ar[8:1]   <= byte_data;
    if (lastbit) ar[0]     <= 1'b0;
    if (ldAm)    ar[16:9]  <= byte_data;
    if (ldBl)    br[7:0]   <= byte_data;
    if (ldBm)    br[15:8]  <= byte_data;
    if (pr_rst)  pr        <= '0;
    if (ldP)     pr        <= sum >>> 2;
    if (shen)    ar        <= {sum[1:0], ar[16:3], ar[2]};
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every wait goes through tick(): one negedge plus the protocol rules.
  int   tot_ldp = 0, tot_prst = 0, tot_done = 0;
  logic prev_done = 1'b0, prev_prst = 1'b0, prev_ldp = 1'b0;

  task automatic tick();
    logic [3:0] exp_ld;
    @(negedge clk);
    if (rst) begin
      prev_done = 1'b0; prev_prst = 1'b0; prev_ldp = 1'b0;
    end else begin
      exp_ld = (byte_req && byte_valid) ? 4'(1 << (3 - int'(byte_sel))) : 4'b0;
      check("ld_decode", {28'd0, ldAl, ldAm, ldBl, ldBm}, {28'd0, exp_ld});
      check("lastbit_eq_ldAl", 32'(lastbit), 32'(ldAl));
      check("ldP_eq_shen", 32'(ldP), 32'(shen));
      check("one_of_ready_busy_done", 32'($countones({ready, busy, done})), 32'd1);
      if (done)                 check("done_single_pulse", 32'(prev_done), 32'd0);
      if (prev_prst)            check("ldP_after_pr_rst", 32'(ldP), 32'd1);
      if (ldP && !prev_ldp)     check("pr_rst_before_ldP", 32'(prev_prst), 32'd1);
      if (ldP || pr_rst)        check("strobe_while_busy", 32'(busy), 32'd1);
      tot_ldp  += int'(ldP);
      tot_prst += int'(pr_rst);
      tot_done += int'(done);
      prev_done = done; prev_prst = pr_rst; prev_ldp = ldP;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          stall_sel;   // -1: no stall
    int          stall_n;
    bit          poke;        // pulse ignored start/byte_valid in IDLE, CALC, DONE
    logic [31:0] exp;
  } vec_t;

  task automatic do_op(input vec_t v, input string nm);
    int k, stalls, p_ldp, p_prst, p_done;
    bit got, poked;
    cur_a = v.a;
    cur_b = v.b;
    if (v.poke) begin
      tick();
      #2 byte_valid = 1'b1;
      tick();
      check({nm, "_idle_valid_ready"}, 32'(ready), 32'd1);
      check({nm, "_idle_valid_req"}, 32'(byte_req), 32'd0);
      #2 byte_valid = 1'b0;
    end
    tick();
    check({nm, "_ready_before"}, 32'(ready), 32'd1);
    p_ldp = tot_ldp; p_prst = tot_prst; p_done = tot_done;
    #2 start = 1'b1;
    byte_valid = 1'b1;
    k = cyc + 1;
    stalls = v.stall_n;
    got = 1'b0;
    poked = 1'b0;
    for (int g = 0; g < 64 && !got; g++) begin
      tick();
      if (done) begin
        got = 1'b1;
        check({nm, "_latency"}, 32'(cyc - k), 32'(13 + v.stall_n));
      end else begin
        #2 start = 1'b0;
        if (v.stall_sel >= 0 && byte_req && int'(byte_sel) == v.stall_sel && stalls > 0) begin
          byte_valid = 1'b0;
          stalls--;
          #1 check({nm, "_stall_no_ld"}, {28'd0, ldAl, ldAm, ldBl, ldBm}, 32'd0);
        end else begin
          byte_valid = 1'b1;
        end
        if (v.poke && ldP && !poked) begin
          start = 1'b1;
          poked = 1'b1;
        end
      end
    end
    if (!got) check({nm, "_done_timeout"}, 32'd0, 32'd1);
    #2 start = v.poke;
    byte_valid = 1'b0;
    tick();
    check({nm, "_idle_after_done"}, 32'(ready), 32'd1);
    check({nm, "_no_restart"}, 32'(byte_req), 32'd0);
    #2 start = 1'b0;
    tick();
    check({nm, "_ldP_cycles"}, 32'(tot_ldp - p_ldp), 32'd8);
    check({nm, "_pr_rst_once"}, 32'(tot_prst - p_prst), 32'd1);
    check({nm, "_done_once"}, 32'(tot_done - p_done), 32'd1);
    check({nm, "_product"}, prod, v.exp);
  endtask

  vec_t vecs[5];

  initial begin
    vec_t rv;
    int   cnt;
    vecs[0] = '{16'h0003, 16'h0005, -1, 0, 1'b0, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'h0002, -1, 0, 1'b0, 32'hFFFFFFFE};
    vecs[2] = '{16'h1234, 16'h0010, -1, 0, 1'b0, 32'h00012340};
    vecs[3] = '{16'h8000, 16'h7FFF,  2, 3, 1'b0, 32'hC0008000};
    vecs[4] = '{16'h00FF, 16'hFF00, -1, 0, 1'b1, 32'hFFFF0100};

    // Reset state
    byte_valid = 1'b1;
    start = 1'b1;
    repeat (2) tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_strobes", {23'd0, byte_req, ldAl, ldAm, ldBl, ldBm, lastbit, pr_rst, ldP, shen},
          32'd0);
    #2 rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    tick();
    check("idle_hold_ready", 32'(ready), 32'd1);

    foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 20; r++) begin
      rv.a = 16'($urandom);
      rv.b = 16'($urandom);
      rv.stall_sel = int'($urandom_range(0, 3));
      rv.stall_n = int'($urandom_range(0, 3));
      rv.poke = 1'($urandom_range(0, 1));
      rv.exp = 32'(int'($signed(rv.a)) * int'($signed(rv.b)));
      do_op(rv, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of CALC after four iterations
    cur_a = 16'h0101;
    cur_b = 16'h0202;
    tick();
    #2 start = 1'b1;
    byte_valid = 1'b1;
    cnt = 0;
    for (int g = 0; g < 64 && cnt < 4; g++) begin
      tick();
      if (ldP) cnt++;
      if (cnt < 4) #2 start = 1'b0;
    end
    check("rst_mid_reached_calc", 32'(cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_strobes", {24'd0, ldAl, ldAm, ldBl, ldBm, lastbit, pr_rst, ldP, shen}, 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    tick();
    #2 rst = 1'b0;
    byte_valid = 1'b0;
    start = 1'b0;
    rv = '{16'h0007, 16'hFFFD, -1, 0, 1'b0, 32'hFFFFFFEB};
    do_op(rv, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
